// File: rtl/wb_button_debounce.sv
// rtl/wb_button_debounce.sv - button synchroniser, per-bit debouncer and Wishbone event/mask registers with irq
module wb_button_debounce #(
   parameter int          NUM_BTN         = 2,
   parameter int          CNT_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] EVENT_ADDRESS   = 32'h3000_0008,
   parameter logic [31:0] MASK_ADDRESS    = 32'h3000_000C
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] buttons_raw,
   output logic [NUM_BTN-1:0] buttons_clean,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic               irq,
   input  logic               i_wb_cyc,
   input  logic               i_wb_stb,
   input  logic               i_wb_we,
   input  logic [31:0]        i_wb_addr,
   input  logic [31:0]        i_wb_data,
   output logic               o_wb_ack,
   output logic               o_wb_stall,
   output logic [31:0]        o_wb_data
);

   // Counter value on which the next differing sample commits the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;
   logic [NUM_BTN-1:0] clean_d;
   logic [CNT_W-1:0]   cnt [NUM_BTN];

   logic [NUM_BTN-1:0] press_strobe;
   logic [NUM_BTN-1:0] release_strobe;
   logic [NUM_BTN-1:0] press_flags;
   logic [NUM_BTN-1:0] release_flags;
   logic [NUM_BTN-1:0] press_mask;
   logic [NUM_BTN-1:0] release_mask;
   logic [NUM_BTN-1:0] clr_press;
   logic [NUM_BTN-1:0] clr_release;

   logic               wb_req;
   logic               hit_event;
   logic               hit_mask;
   logic [31:0]        event_word;
   logic [31:0]        mask_word;
   logic [31:0]        rd_word;
   logic               unused_wdata;

   // Press flags sit in the low byte, release flags in the second byte; everything else reads 0.
   function automatic logic [31:0] pack_word(input logic [NUM_BTN-1:0] lo,
                                             input logic [NUM_BTN-1:0] hi);
      logic [31:0] w;
      w = '0;
      w[NUM_BTN-1:0] = lo;
      w[8 +: NUM_BTN] = hi;
      return w;
   endfunction

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= buttons_raw;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: commit a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buttons_clean <= '1;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2[i] == buttons_clean[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               buttons_clean[i] <= sync2[i];
               cnt[i]           <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Delayed copy of the clean level for edge detection, and the registered press pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clean_d     <= '1;
         press_pulse <= '0;
      end else begin
         clean_d     <= buttons_clean;
         press_pulse <= press_strobe;
      end
   end

   assign press_strobe   = clean_d & ~buttons_clean;
   assign release_strobe = ~clean_d & buttons_clean;

   assign wb_req     = i_wb_cyc & i_wb_stb;
   assign hit_event  = wb_req && (i_wb_addr == EVENT_ADDRESS);
   assign hit_mask   = wb_req && (i_wb_addr == MASK_ADDRESS);
   assign o_wb_stall = 1'b0;

   assign clr_press   = (hit_event && i_wb_we) ? i_wb_data[NUM_BTN-1:0] : '0;
   assign clr_release = (hit_event && i_wb_we) ? i_wb_data[8 +: NUM_BTN] : '0;

   // Data bits outside the two flag fields carry nothing for this block.
   assign unused_wdata = ^i_wb_data;

   assign event_word = pack_word(press_flags, release_flags);
   assign mask_word  = pack_word(press_mask, release_mask);

   // Read mux built from the current register state, so reads see pre-write values.
   always_comb begin
      rd_word = '0;
      if (hit_event) begin
         rd_word = event_word;
      end else if (hit_mask) begin
         rd_word = mask_word;
      end
   end

   // Sticky event flags: write-1-to-clear, with a same-cycle set overriding the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         press_flags   <= '0;
         release_flags <= '0;
      end else begin
         press_flags   <= (press_flags & ~clr_press) | press_strobe;
         release_flags <= (release_flags & ~clr_release) | release_strobe;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         press_mask   <= '0;
         release_mask <= '0;
      end else if (hit_mask && i_wb_we) begin
         press_mask   <= i_wb_data[NUM_BTN-1:0];
         release_mask <= i_wb_data[8 +: NUM_BTN];
      end
   end

   // Level interrupt from the previous cycle's flag and mask state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= |((press_flags & press_mask) | (release_flags & release_mask));
      end
   end

   // Single-cycle Wishbone response; unmapped addresses get no ack and load zero data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack  <= hit_event | hit_mask;
         o_wb_data <= rd_word;
      end
   end

endmodule

// File: tb/tb_wb_button_debounce.sv
// tb/tb_wb_button_debounce.sv - self-checking bench for wb_button_debounce
module tb_wb_button_debounce;

   localparam int          DB    = 4;
   localparam logic [31:0] EVT_A = 32'h3000_0008;
   localparam logic [31:0] MSK_A = 32'h3000_000C;
   localparam logic [31:0] BAD_A = 32'h3000_0010;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  raw;
   logic        cyc, stb, we;
   logic [31:0] addr, wdata;
   logic [1:0]  buttons_clean, press_pulse;
   logic        irq, o_wb_ack, o_wb_stall;
   logic [31:0] o_wb_data;

   int checks_total  = 0;
   int checks_passed = 0;

   wb_button_debounce #(
      .NUM_BTN(2), .CNT_W(16), .DEBOUNCE_CYCLES(DB),
      .EVENT_ADDRESS(EVT_A), .MASK_ADDRESS(MSK_A)
   ) dut (
      .clk(clk), .reset(reset), .buttons_raw(raw),
      .buttons_clean(buttons_clean), .press_pulse(press_pulse), .irq(irq),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata),
      .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wb_read(input logic [31:0] a, output logic ack, output logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1;
      ack = o_wb_ack; d = o_wb_data;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] v, output logic ack);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = v;
      @(posedge clk); #1;
      ack = o_wb_ack;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      logic ack; logic [31:0] d;
      reset = 1'b1; raw = 2'b11; cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk); #1;
      checks_total++; if (buttons_clean !== 2'b11) $display("FAIL reset_clean: got %b want 11", buttons_clean); else checks_passed++;
      checks_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else checks_passed++;
      checks_total++; if (press_pulse !== 2'b00) $display("FAIL reset_pulse: got %b want 00", press_pulse); else checks_passed++;
      checks_total++; if (o_wb_ack !== 1'b0 || o_wb_data !== 32'h0) $display("FAIL reset_wb: got ack %b data %h want 0/0", o_wb_ack, o_wb_data); else checks_passed++;
      @(negedge clk); reset = 1'b0;
      wb_read(EVT_A, ack, d);
      checks_total++; if (ack !== 1'b1 || d !== 32'h0) $display("FAIL reset_evt_read: got ack %b data %h want 1/0", ack, d); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (o_wb_ack !== 1'b0) $display("FAIL reset_ack_drop: got %b want 0", o_wb_ack); else checks_passed++;
   endtask

   task automatic test_back_to_back();
      logic a1, a2, a3, a4, ack; logic [31:0] d2, d3;
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; addr = MSK_A; wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1; a1 = o_wb_ack; we = 0; addr = MSK_A;
      @(posedge clk); #1; a2 = o_wb_ack; d2 = o_wb_data; addr = BAD_A;
      @(posedge clk); #1; a3 = o_wb_ack; d3 = o_wb_data; cyc = 0; addr = EVT_A;
      @(posedge clk); #1; a4 = o_wb_ack; stb = 0;
      checks_total++; if (a1 !== 1'b1) $display("FAIL b2b_write_ack: got %b want 1", a1); else checks_passed++;
      checks_total++; if (a2 !== 1'b1 || d2 !== 32'h0000_0303) $display("FAIL b2b_mask_read: got ack %b data %h want 1/00000303", a2, d2); else checks_passed++;
      checks_total++; if (a3 !== 1'b0 || d3 !== 32'h0) $display("FAIL b2b_unmapped: got ack %b data %h want 0/0", a3, d3); else checks_passed++;
      checks_total++; if (a4 !== 1'b0) $display("FAIL b2b_no_cyc: got ack %b want 0", a4); else checks_passed++;
      checks_total++; if (irq !== 1'b0) $display("FAIL b2b_irq: got %b want 0", irq); else checks_passed++;
      wb_write(MSK_A, 32'h0, ack);
   endtask

   task automatic test_clean_press();
      logic ack; logic [31:0] d;
      @(negedge clk); raw[0] = 1'b0;
      @(posedge clk);
      repeat (4) @(posedge clk); #1;
      checks_total++; if (buttons_clean !== 2'b11) $display("FAIL press_early: got %b want 11", buttons_clean); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (buttons_clean !== 2'b10) $display("FAIL press_clean: got %b want 10", buttons_clean); else checks_passed++;
      checks_total++; if (press_pulse !== 2'b00) $display("FAIL press_pulse_early: got %b want 00", press_pulse); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (press_pulse !== 2'b01) $display("FAIL press_pulse: got %b want 01", press_pulse); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (press_pulse !== 2'b00) $display("FAIL press_pulse_width: got %b want 00", press_pulse); else checks_passed++;
      wb_read(EVT_A, ack, d);
      checks_total++; if (ack !== 1'b1 || d !== 32'h0000_0001) $display("FAIL press_evt: got ack %b data %h want 1/00000001", ack, d); else checks_passed++;
      checks_total++; if (irq !== 1'b0) $display("FAIL press_irq_masked: got %b want 0", irq); else checks_passed++;
   endtask

   task automatic test_bounce();
      logic ack; logic [31:0] d; int bad; int pulses;
      bad = 0; pulses = 0;
      for (int ph = 0; ph < 10; ph++) begin
         for (int c = 0; c < 2; c++) begin
            @(negedge clk); raw[1] = (ph % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (buttons_clean[1] !== 1'b1) bad++;
            pulses += int'(press_pulse[1]);
         end
      end
      @(negedge clk); raw[1] = 1'b0;
      @(posedge clk); #1;
      if (buttons_clean[1] !== 1'b1) bad++;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (buttons_clean[1] !== 1'b1) bad++;
      end
      checks_total++; if (bad !== 0) $display("FAIL bounce_stable: got %0d early changes want 0", bad); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (buttons_clean[1] !== 1'b0) $display("FAIL bounce_clean: got %b want 0", buttons_clean[1]); else checks_passed++;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         pulses += int'(press_pulse[1]);
      end
      checks_total++; if (pulses !== 1) $display("FAIL bounce_pulses: got %0d want 1", pulses); else checks_passed++;
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0003) $display("FAIL bounce_evt: got %h want 00000003", d); else checks_passed++;
      wb_write(EVT_A, 32'h0000_0002, ack);
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0001) $display("FAIL bounce_w1c: got %h want 00000001", d); else checks_passed++;
   endtask

   task automatic test_release_irq();
      logic ack; logic [31:0] d;
      wb_write(MSK_A, 32'h0000_0100, ack);
      checks_total++; if (ack !== 1'b1) $display("FAIL rel_mask_ack: got %b want 1", ack); else checks_passed++;
      @(negedge clk); raw[0] = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk); #1;
      checks_total++; if (buttons_clean[0] !== 1'b1) $display("FAIL rel_clean: got %b want 1", buttons_clean[0]); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (irq !== 1'b0) $display("FAIL rel_irq_early: got %b want 0", irq); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (irq !== 1'b1) $display("FAIL rel_irq: got %b want 1", irq); else checks_passed++;
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0101) $display("FAIL rel_evt: got %h want 00000101", d); else checks_passed++;
      wb_write(EVT_A, 32'h0000_0100, ack);
      checks_total++; if (irq !== 1'b1) $display("FAIL rel_irq_hold: got %b want 1", irq); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (irq !== 1'b0) $display("FAIL rel_irq_fall: got %b want 0", irq); else checks_passed++;
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0001) $display("FAIL rel_evt_after: got %h want 00000001", d); else checks_passed++;
   endtask

   task automatic test_set_wins();
      logic ack; logic [31:0] d;
      wb_write(EVT_A, 32'h0000_0001, ack);
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0) $display("FAIL setwins_pre: got %h want 0", d); else checks_passed++;
      @(negedge clk); raw[0] = 1'b0;
      @(posedge clk);
      repeat (5) @(posedge clk);
      wb_write(EVT_A, 32'h0000_0001, ack);
      checks_total++; if (press_pulse[0] !== 1'b1) $display("FAIL setwins_align: got pulse %b want 1", press_pulse[0]); else checks_passed++;
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0001) $display("FAIL setwins_evt: got %h want 00000001", d); else checks_passed++;
   endtask

   task automatic test_reset_midcount();
      logic ack; logic [31:0] d;
      @(negedge clk); raw = 2'b11;
      repeat (10) @(posedge clk);
      wb_write(EVT_A, 32'h0000_0303, ack);
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0 || buttons_clean !== 2'b11) $display("FAIL rmid_pre: got evt %h clean %b want 0/11", d, buttons_clean); else checks_passed++;
      @(negedge clk); raw[0] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); reset = 1'b1; #1;
      checks_total++; if (buttons_clean !== 2'b11 || press_pulse !== 2'b00 || irq !== 1'b0) $display("FAIL rmid_in_reset: got clean %b pulse %b irq %b want 11/00/0", buttons_clean, press_pulse, irq); else checks_passed++;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      wb_read(MSK_A, ack, d);
      checks_total++; if (ack !== 1'b1 || d !== 32'h0) $display("FAIL rmid_mask: got ack %b data %h want 1/0", ack, d); else checks_passed++;
      repeat (3) @(posedge clk); #1;
      checks_total++; if (buttons_clean !== 2'b11) $display("FAIL rmid_restart: got %b want 11", buttons_clean); else checks_passed++;
      @(posedge clk); #1;
      checks_total++; if (buttons_clean !== 2'b10) $display("FAIL rmid_clean: got %b want 10", buttons_clean); else checks_passed++;
      @(posedge clk);
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== 32'h0000_0001) $display("FAIL rmid_evt: got %h want 00000001", d); else checks_passed++;
   endtask

   task automatic test_random();
      logic ack; logic [31:0] d; logic [31:0] exp_evt;
      logic [1:0] q[$]; logic [1:0] m_clean, m_prev, seen, exp_pulse;
      int run[2]; int press_cnt[2]; int rel_cnt[2]; int hold; int bad_clean, bad_pulse;
      wb_write(EVT_A, 32'h0000_0303, ack);
      wb_write(MSK_A, 32'h0000_0303, ack);
      q.delete(); q.push_back(raw); q.push_back(raw);
      m_clean = raw; m_prev = raw;
      for (int i = 0; i < 2; i++) begin run[i] = 0; press_cnt[i] = 0; rel_cnt[i] = 0; end
      hold = 0; bad_clean = 0; bad_pulse = 0;
      for (int n = 0; n < 412; n++) begin
         @(negedge clk);
         if (n < 400) begin
            if (hold == 0) begin
               raw  = 2'($urandom_range(0, 3));
               hold = int'($urandom_range(1, 7));
            end
            hold--;
         end
         @(posedge clk); #1;
         seen = q.pop_front();
         q.push_back(raw);
         exp_pulse = m_prev & ~m_clean;
         for (int i = 0; i < 2; i++) begin
            if (m_prev[i] && !m_clean[i]) press_cnt[i]++;
            if (!m_prev[i] && m_clean[i]) rel_cnt[i]++;
         end
         m_prev = m_clean;
         for (int i = 0; i < 2; i++) begin
            if (seen[i] != m_clean[i]) begin
               run[i]++;
               if (run[i] == DB) begin
                  m_clean[i] = seen[i];
                  run[i] = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
         checks_total++;
         if (buttons_clean !== m_clean) begin
            if (bad_clean < 5) $display("FAIL rand_clean cycle %0d: got %b want %b", n, buttons_clean, m_clean);
            bad_clean++;
         end else checks_passed++;
         checks_total++;
         if (press_pulse !== exp_pulse) begin
            if (bad_pulse < 5) $display("FAIL rand_pulse cycle %0d: got %b want %b", n, press_pulse, exp_pulse);
            bad_pulse++;
         end else checks_passed++;
      end
      exp_evt = '0;
      for (int i = 0; i < 2; i++) begin
         exp_evt[i]     = (press_cnt[i] > 0);
         exp_evt[8 + i] = (rel_cnt[i] > 0);
      end
      wb_read(EVT_A, ack, d);
      checks_total++; if (d !== exp_evt) $display("FAIL rand_evt: got %h want %h", d, exp_evt); else checks_passed++;
      checks_total++; if (irq !== (exp_evt != 32'h0)) $display("FAIL rand_irq: got %b want %b", irq, (exp_evt != 32'h0)); else checks_passed++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_clean_press();
      test_bounce();
      test_release_irq();
      test_set_wins();
      test_reset_midcount();
      test_random();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/wb_button_debounce.md
# wb_button_debounce

Input-conditioning stage sitting directly upstream of the button/LED Wishbone peripheral. Synchronises the raw button pads, debounces each bit with a per-button counter, and drives the clean level onto that peripheral's `buttons` input. Also latches press and release events in a Wishbone-visible, write-1-to-clear register with a maskable interrupt, so firmware does not have to poll button levels.

## Interface

Parameters:
- `NUM_BTN`, 2: number of buttons, 1..8.
- `CNT_W`, 16: debounce counter width.
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable cycles required; legal range 1..2^CNT_W-1.
- `EVENT_ADDRESS`, 32'h3000_0008: event register address.
- `MASK_ADDRESS`, 32'h3000_000C: interrupt mask register address.

Ports:
- `clk` in 1: single clock (Wishbone clock).
- `reset` in 1: asynchronous, active-high; all flops clear on assertion.
- `buttons_raw` in NUM_BTN: pad inputs, active-low (0 = pressed), asynchronous to `clk`.
- `buttons_clean` out NUM_BTN: debounced level, same active-low polarity; feeds the button/LED peripheral's `buttons` input.
- `press_pulse` out NUM_BTN: one-cycle pulse per debounced press (1→0 on clean).
- `irq` out 1: level interrupt, `|(events & mask)`, registered.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1 each: Wishbone cycle, strobe and write enable.
- `i_wb_addr` in 32, `i_wb_data` in 32: Wishbone address and write data.
- `o_wb_ack` out 1, `o_wb_stall` out 1 (tied 0), `o_wb_data` out 32: Wishbone response.

## Operation

- **Synchroniser:** two flops per bit (`sync1`, `sync2`), reset value all-ones (released).
- **Debounce, per bit i:**
  - If `sync2[i] == clean[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `clean[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - Any glitch back to the clean level restarts the count. The counter never wraps.
- **Events:** `press[i]` = clean falls 1→0; `release[i]` = clean rises 0→1. Each is a single-cycle internal strobe.
  - `press_pulse[i]` is registered and asserts the cycle after `clean[i]` falls.
- **Event register (EVENT_ADDRESS):**
  - Bits [NUM_BTN-1:0] are sticky press flags.
  - Bits [8+NUM_BTN-1:8] are sticky release flags.
  - All other bits read 0.
  - Write: each 1 in `i_wb_data` clears the matching flag.
  - A set strobe and a clear in the same cycle leave the flag set (set wins).
- **Mask register (MASK_ADDRESS):** read/write, same bit layout as the event register; unused bits read 0.
- **irq:** registered `|(events & mask)`; reflects the register state of the previous cycle.
- **Wishbone:**
  - A request is `i_wb_cyc && i_wb_stb`; `o_wb_stall` = 0.
  - A request to either address returns `o_wb_ack` = 1 on the next cycle. Other addresses get no ack, so the peripheral ignores them.
  - Read data is registered in the same cycle as the ack; reads from non-matching addresses load 0.
  - A write updates the register on the clock edge that accepts it.
  - Read data is the pre-write value for any event set or clear landing in the same cycle.
- **Reset values:** `buttons_clean` all-ones; `press_pulse` 0; `irq` 0; events 0; mask 0; counters 0; `o_wb_ack` 0; `o_wb_data` 0.

## Timing

- **Raw to clean:** a pad change held stable and first sampled at edge t appears on `buttons_clean` after edge t+1+DEBOUNCE_CYCLES.
  - That is 2 synchroniser edges followed by DEBOUNCE_CYCLES consecutive differing samples.
- **Clean to `press_pulse`:** +1 cycle. Clean to event flag: +1 cycle. Event flag to `irq`: +1 cycle.
- **Wishbone:** single-cycle ack latency; back-to-back requests are accepted every cycle.
- **Reset mid-count:** counter, clean level and flags return to reset values immediately (asynchronous); no event is generated by reset.
- **Simultaneous presses** on multiple bits set all corresponding flags in the same cycle.

## Test plan

Run with DEBOUNCE_CYCLES=4.

1. **Reset:** hold reset with `buttons_raw`=2'b11 → `buttons_clean`=2'b11, `irq`=0, read of EVENT_ADDRESS returns 0 with ack one cycle after stb.
2. **Clean press:** drive `buttons_raw[0]`=0 at edge t → `buttons_clean[0]`=0 after edge t+5; `press_pulse[0]` high exactly one cycle; EVENT read = 32'h0000_0001.
3. **Bounce:** toggle `buttons_raw[1]` 0/1 every 2 cycles for 20 cycles, then hold 0 → no clean change during the bouncing; clean goes 0 exactly 6 edges after the final stable 0 is first sampled; only one press event.
4. **Release and irq:**
   - Write MASK = 32'h0000_0100, then release button 0 → EVENT = 32'h0000_0101 and `irq`=1.
   - Write EVENT = 32'h0000_0100 → `irq` falls 1 cycle after the flag clears; press flag remains.
5. **Set-wins collision:** issue the W1C write of bit 0 on the same edge a new press of button 0 is detected → bit 0 remains 1.
6. **Reset mid-count:** assert reset while the counter is at 2 → clean stays 1, no event, counter restarts from 0 after reset release.
